// File: rtl/cmp_sweep_checker.sv
// Built-in self-test sweep engine for a WIDTH-bit magnitude comparator.
// Walks every {a,b} pair, samples e/g/l after SETTLE extra cycles, and records mismatches.
module cmp_sweep_checker #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  input  logic               e_in,
  input  logic               g_in,
  input  logic               l_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               first_fail_valid,
  output logic [2*WIDTH-1:0] first_fail_vec
);

  localparam int unsigned VW = 2 * WIDTH;
  localparam int unsigned CW = VW + 1;

  localparam logic [3:0]    SETTLE_C = 4'(SETTLE);
  localparam logic [VW-1:0] IDX_INC  = VW'(1);
  localparam logic [CW-1:0] ERR_INC  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [VW-1:0]   idx_q, idx_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [CW-1:0]   err_count_q, err_count_d;
  logic            ffv_q, ffv_d;
  logic [VW-1:0]   ffvec_q, ffvec_d;
  logic            pass_q, pass_d;

  logic [WIDTH-1:0] cur_a;
  logic [WIDTH-1:0] cur_b;
  logic [2:0]       exp_egl;
  logic             mismatch;

  // Reference is taken from the registered index, i.e. the operands currently on the pins.
  always_comb begin
    cur_a    = idx_q[VW-1:WIDTH];
    cur_b    = idx_q[WIDTH-1:0];
    exp_egl  = {cur_a == cur_b, cur_a > cur_b, cur_a < cur_b};
    mismatch = ({e_in, g_in, l_in} != exp_egl);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    err_count_d = err_count_q;
    ffv_d       = ffv_q;
    ffvec_d     = ffvec_q;
    pass_d      = pass_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          idx_d       = '0;
          cnt_d       = '0;
          err_count_d = '0;
          ffv_d       = 1'b0;
          ffvec_d     = '0;
          pass_d      = 1'b0;
        end
      end

      S_RUN: begin
        if (cnt_q != SETTLE_C) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          if (mismatch) begin
            err_count_d = err_count_q + ERR_INC;
            if (!ffv_q) begin
              ffv_d   = 1'b1;
              ffvec_d = idx_q;
            end
          end
          // pass must reflect this final check, so it looks at mismatch, not only the old count.
          if (idx_q == '1) begin
            state_d = S_DONE;
            pass_d  = !mismatch && (err_count_q == '0);
          end else begin
            idx_d = idx_q + IDX_INC;
            cnt_d = '0;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      err_count_q <= '0;
      ffv_q       <= 1'b0;
      ffvec_q     <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      err_count_q <= err_count_d;
      ffv_q       <= ffv_d;
      ffvec_q     <= ffvec_d;
      pass_q      <= pass_d;
    end
  end

  // In DONE the index rests at all-ones, so the operand outputs hold 'hF/'hF.
  always_comb begin
    a_out            = idx_q[VW-1:WIDTH];
    b_out            = idx_q[WIDTH-1:0];
    busy             = (state_q == S_RUN);
    done             = (state_q == S_DONE);
    pass             = pass_q;
    err_count        = err_count_q;
    first_fail_valid = ffv_q;
    first_fail_vec   = ffvec_q;
  end

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// Table-driven bench: two checker instances (SETTLE=2 and SETTLE=0), each driving a
// behavioural comparator with selectable faults.
module tb_cmp_sweep_checker;

  logic clk;
  logic rst_n;
  logic start0, start1;
  int   fm0, fm1;
  int   sel;

  logic [3:0] a0, b0, a1, b1;
  logic       e0, g0, l0, e1, g1, l1;
  logic       busy0, done0, pass0, ffv0, busy1, done1, pass1, ffv1;
  logic [8:0] err0, err1;
  logic [7:0] vec0, vec1;

  logic       s_busy, s_done, s_pass, s_ffv;
  logic [3:0] s_a, s_b;
  logic [8:0] s_err;
  logic [7:0] s_vec;

  int checks;
  int errors;

  cmp_sweep_checker #(.WIDTH(4), .SETTLE(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a_out(a0), .b_out(b0),
    .e_in(e0), .g_in(g0), .l_in(l0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail_valid(ffv0), .first_fail_vec(vec0)
  );

  cmp_sweep_checker #(.WIDTH(4), .SETTLE(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_out(a1), .b_out(b1),
    .e_in(e1), .g_in(g1), .l_in(l1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_valid(ffv1), .first_fail_vec(vec1)
  );

  // Fault modes: 0 ideal, 1 e tied 0, 2 g/l swapped, 3 g stuck 1, 4 l tied 0, 5 all ones.
  function automatic logic [2:0] cmp_model(input int mode, input logic [3:0] a, input logic [3:0] b);
    logic e, g, l;
    e = (a == b);
    g = (a > b);
    l = (a < b);
    case (mode)
      1:       return {1'b0, g, l};
      2:       return {e, l, g};
      3:       return {e, 1'b1, l};
      4:       return {e, g, 1'b0};
      5:       return 3'b111;
      default: return {e, g, l};
    endcase
  endfunction

  always_comb {e0, g0, l0} = cmp_model(fm0, a0, b0);
  always_comb {e1, g1, l1} = cmp_model(fm1, a1, b1);

  always_comb begin
    s_busy = (sel == 1) ? busy1 : busy0;
    s_done = (sel == 1) ? done1 : done0;
    s_pass = (sel == 1) ? pass1 : pass0;
    s_ffv  = (sel == 1) ? ffv1  : ffv0;
    s_a    = (sel == 1) ? a1    : a0;
    s_b    = (sel == 1) ? b1    : b0;
    s_err  = (sel == 1) ? err1  : err0;
    s_vec  = (sel == 1) ? vec1  : vec0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " busy"}, int'(s_busy), 0);
    chk({tag, " done"}, int'(s_done), 0);
    chk({tag, " pass"}, int'(s_pass), 0);
    chk({tag, " err_count"}, int'(s_err), 0);
    chk({tag, " ffv"}, int'(s_ffv), 0);
    chk({tag, " ffvec"}, int'(s_vec), 0);
    chk({tag, " a_out"}, int'(s_a), 0);
    chk({tag, " b_out"}, int'(s_b), 0);
  endtask

  // Counts edges after the current one until done is seen; busy must stay high meanwhile.
  task automatic wait_done(output int n, output int gaps);
    n = 0;
    gaps = 0;
    while (n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (s_done) break;
      if (!s_busy) gaps++;
    end
  endtask

  task automatic pulse_start(input int inst);
    @(negedge clk);
    if (inst == 1) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    chk("t0 busy", int'(s_busy), 1);
    chk("t0 a_out", int'(s_a), 0);
    chk("t0 b_out", int'(s_b), 0);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  typedef struct {
    string name;
    int    inst;
    int    mode;
    int    exp_err;
    int    exp_ffv;
    int    exp_vec;
    int    exp_pass;
    int    exp_cyc;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int n, gaps;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    fm0    = 0;
    fm1    = 0;
    sel    = 0;

    tbl[0] = '{"s2 ideal",     0, 0,   0, 0, 8'h00, 1, 768};
    tbl[1] = '{"s2 e_tied0",   0, 1,  16, 1, 8'h00, 0, 768};
    tbl[2] = '{"s2 gl_swap",   0, 2, 240, 1, 8'h01, 0, 768};
    tbl[3] = '{"s2 g_stuck1",  0, 3, 136, 1, 8'h00, 0, 768};
    tbl[4] = '{"s2 l_tied0",   0, 4, 120, 1, 8'h01, 0, 768};
    tbl[5] = '{"s2 all_ones",  0, 5, 256, 1, 8'h00, 0, 768};
    tbl[6] = '{"s0 ideal",     1, 0,   0, 0, 8'h00, 1, 256};
    tbl[7] = '{"s0 g_stuck1",  1, 3, 136, 1, 8'h00, 0, 256};
    tbl[8] = '{"s0 gl_swap",   1, 2, 240, 1, 8'h01, 0, 256};

    #1;
    sel = 0;
    #1 check_zero("reset0");
    sel = 1;
    #1 check_zero("reset1");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      sel = tbl[i].inst;
      if (tbl[i].inst == 1) fm1 = tbl[i].mode; else fm0 = tbl[i].mode;
      pulse_start(tbl[i].inst);
      wait_done(n, gaps);
      chk({tbl[i].name, " cycles"}, n, tbl[i].exp_cyc);
      chk({tbl[i].name, " busy_gaps"}, gaps, 0);
      chk({tbl[i].name, " done"}, int'(s_done), 1);
      chk({tbl[i].name, " busy"}, int'(s_busy), 0);
      chk({tbl[i].name, " pass"}, int'(s_pass), tbl[i].exp_pass);
      chk({tbl[i].name, " err_count"}, int'(s_err), tbl[i].exp_err);
      chk({tbl[i].name, " ffv"}, int'(s_ffv), tbl[i].exp_ffv);
      if (tbl[i].exp_ffv != 0)
        chk({tbl[i].name, " ffvec"}, int'(s_vec), tbl[i].exp_vec);
      chk({tbl[i].name, " a_out"}, int'(s_a), 15);
      chk({tbl[i].name, " b_out"}, int'(s_b), 15);
      repeat (3) @(posedge clk);
      #1;
      chk({tbl[i].name, " done_held"}, int'(s_done), 1);
      chk({tbl[i].name, " err_held"}, int'(s_err), tbl[i].exp_err);
    end

    // Asynchronous reset mid-sweep, with errors already accumulated.
    sel = 0;
    fm0 = 1;
    pulse_start(0);
    repeat (300) @(posedge clk);
    #1;
    chk("pre_rst busy", int'(s_busy), 1);
    chk("pre_rst ffv", int'(s_ffv), 1);
    #2;
    rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst idle busy", int'(s_busy), 0);
    chk("post_rst idle done", int'(s_done), 0);
    fm0 = 0;
    pulse_start(0);
    wait_done(n, gaps);
    chk("post_rst cycles", n, 768);
    chk("post_rst pass", int'(s_pass), 1);
    chk("post_rst err_count", int'(s_err), 0);

    // start held high: ignored in RUN, restarts on the first DONE edge.
    fm0 = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    #1;
    chk("held t0 busy", int'(s_busy), 1);
    wait_done(n, gaps);
    chk("held cycles1", n, 768);
    chk("held gaps1", gaps, 0);
    chk("held err1", int'(s_err), 16);
    chk("held pass1", int'(s_pass), 0);
    @(posedge clk);
    #1;
    chk("held restart done", int'(s_done), 0);
    chk("held restart busy", int'(s_busy), 1);
    chk("held restart err", int'(s_err), 0);
    chk("held restart ffv", int'(s_ffv), 0);
    chk("held restart a_out", int'(s_a), 0);
    chk("held restart b_out", int'(s_b), 0);
    wait_done(n, gaps);
    chk("held cycles2", n, 768);
    chk("held err2", int'(s_err), 16);
    chk("held ffvec2", int'(s_vec), 0);
    @(negedge clk);
    start0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("held stop done", int'(s_done), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
